// File: rtl/i2s_tape_audio_if.sv
// i2s_tape_audio_if: audio sources, codec pins and tape/strobe outputs of the I2S tape audio block
interface i2s_tape_audio_if;
  logic [3:0] pulses;
  logic [7:0] pcm;
  logic iAUD_ADCDAT;
  logic oAUD_BCK;
  logic oAUD_DACLRCK;
  logic oAUD_ADCLRCK;
  logic oAUD_DATA;
  logic tapein;
  logic sample_strobe;
  modport master (
    input pulses, pcm, iAUD_ADCDAT,
    output oAUD_BCK, oAUD_DACLRCK, oAUD_ADCLRCK, oAUD_DATA, tapein, sample_strobe
  );
  modport slave (
    output pulses, pcm, iAUD_ADCDAT,
    input oAUD_BCK, oAUD_DACLRCK, oAUD_ADCLRCK, oAUD_DATA, tapein, sample_strobe
  );
endinterface

// File: rtl/i2s_tape_audio.sv
// i2s_tape_audio: WM8731 I2S master mixing PCM and pulse sources to both DAC channels.
// Define AUDIO_ADC_EN to build left-channel ADC capture with a hysteresis comparator driving tapein.
module i2s_tape_audio #(
  parameter int unsigned BCLK_DIV = 12,
  parameter logic signed [15:0] PULSE_AMP = 16'sh0800,
  parameter logic signed [15:0] HYST = 16'sh0200
) (
  input logic clk18,
  input logic reset_in,
  i2s_tape_audio_if.master io
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam logic [DW-1:0] HALF = DW'(BCLK_DIV / 2);
  localparam logic [DW-1:0] LAST = DW'(BCLK_DIV - 1);
  localparam logic signed [17:0] AMP = 18'(PULSE_AMP);
  logic [DW-1:0] div_cnt, div_nxt;
  logic [4:0] bit_cnt, bit_nxt, idx;
  logic [31:0] frame_word, word_nxt;
  logic [7:0] pcm_x;
  logic signed [17:0] mix;
  logic [15:0] sample16;
  logic wrap, latch;
  assign pcm_x = io.pcm ^ 8'h80;
  always_comb begin
    mix = {{10{pcm_x[7]}}, pcm_x} << 7;
    for (int i = 0; i < 4; i++) mix = mix + (io.pulses[i] ? AMP : -AMP);
  end
  assign sample16 = mix > 18'sd32767 ? 16'h7fff : mix < -18'sd32768 ? 16'h8000 : mix[15:0];
  assign wrap = div_cnt == LAST;
  assign div_nxt = wrap ? '0 : div_cnt + 1'b1;
  assign bit_nxt = bit_cnt + 5'(wrap);
  assign latch = wrap && bit_cnt == 5'd0;
  assign word_nxt = latch ? {sample16, sample16} : frame_word;
  // slot n carries bit 32-n, so slot 0 replays the previous right-channel LSB
  assign idx = 5'd0 - bit_nxt;
  always_ff @(posedge clk18) begin
    if (reset_in) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      frame_word <= '0;
      io.oAUD_BCK <= 1'b0;
      io.oAUD_DACLRCK <= 1'b0;
      io.oAUD_ADCLRCK <= 1'b0;
      io.oAUD_DATA <= 1'b0;
      io.sample_strobe <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      frame_word <= word_nxt;
      io.oAUD_BCK <= div_nxt >= HALF;
      io.oAUD_DACLRCK <= bit_nxt[4];
      io.oAUD_ADCLRCK <= bit_nxt[4];
      io.oAUD_DATA <= word_nxt[idx];
      io.sample_strobe <= latch;
    end
  end
`ifdef AUDIO_ADC_EN
  logic [15:0] adc_sr;
  logic rise, in_left, cmp;
  assign rise = div_cnt == HALF - 1'b1;
  assign in_left = (bit_cnt - 5'd1) < 5'd16;
  assign cmp = div_cnt == HALF && bit_cnt == 5'd16;
  always_ff @(posedge clk18) begin
    if (reset_in) begin
      adc_sr <= '0;
      io.tapein <= 1'b0;
    end else begin
      if (rise && in_left) adc_sr <= {adc_sr[14:0], io.iAUD_ADCDAT};
      if (cmp) io.tapein <= signed'(adc_sr) > HYST ? 1'b1 : signed'(adc_sr) < -HYST ? 1'b0 : io.tapein;
    end
  end
`else
  assign io.tapein = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_tape_audio.sv
// tb_i2s_tape_audio: cycle-model and scoreboard bench for framing, mixing, saturation, ADC hysteresis and reset
module tb_i2s_tape_audio;
  logic clk18 = 1'b0;
  logic reset_in = 1'b1;
  always #5 clk18 = ~clk18;
  i2s_tape_audio_if a();
  i2s_tape_audio_if b();
  assign b.pcm = a.pcm;
  assign b.pulses = a.pulses;
  assign b.iAUD_ADCDAT = a.iAUD_ADCDAT;
  i2s_tape_audio dut (.clk18(clk18), .reset_in(reset_in), .io(a.master));
  i2s_tape_audio #(.PULSE_AMP(16'sh4000)) dut_sat (.clk18(clk18), .reset_in(reset_in), .io(b.master));
  int vectors = 0, errors = 0;
  int t = 0, f = 0;
  logic [31:0] sbq[$];
  logic adcq[$];
  logic [31:0] cur, rx_a, rx_b;
  logic [15:0] adc_w;
  logic [1:0] prev_data;
  logic have_left, tm, tape_exp;
  logic [7:0] pcm_tab[8] = '{8'hFF, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h7F, 8'h01, 8'hFE};
  logic [3:0] pul_tab[8] = '{4'h0, 4'h0, 4'hF, 4'h5, 4'hF, 4'hA, 4'h3, 4'hC};
  logic [15:0] adc_tab[8] = '{16'h0300, 16'h0100, 16'hFD00, 16'hFF00, 16'h0201, 16'h0200, 16'hFE00, 16'hFDFF};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %h exp %h", tag, t, got, exp);
    end
  endtask
  function automatic logic [15:0] mix_model(input logic [7:0] p, input logic [3:0] pu, input int amp);
    int m = (int'(p) - 128) * 128;
    for (int i = 0; i < 4; i++) m += pu[i] ? amp : -amp;
    return m > 32767 ? 16'h7fff : m < -32768 ? 16'h8000 : 16'(m);
  endfunction
  task automatic clear_model();
    t = 0;
    have_left = 1'b0;
    tm = 1'b0;
    tape_exp = 1'b0;
    prev_data = 2'b00;
    rx_a = '0;
    rx_b = '0;
    sbq.delete();
    adcq.delete();
  endtask
  task automatic chk_reset();
    chk("rst_out", {a.oAUD_BCK, a.oAUD_DACLRCK, a.oAUD_ADCLRCK, a.oAUD_DATA, a.tapein, a.sample_strobe,
                    b.oAUD_BCK, b.oAUD_DATA, b.sample_strobe}, 32'd0);
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      int ph, dv, slot;
      ph = t % 384;
      dv = t % 12;
      slot = ph / 12;
      chk("bck", {a.oAUD_BCK, b.oAUD_BCK}, {2{dv >= 6}});
      chk("lrck", {a.oAUD_DACLRCK, a.oAUD_ADCLRCK, b.oAUD_DACLRCK}, {3{slot >= 16}});
      chk("strobe", {a.sample_strobe, b.sample_strobe}, {2{ph == 12}});
      if (t != 0 && dv != 0) chk("data_hold", {a.oAUD_DATA, b.oAUD_DATA}, prev_data);
      prev_data = {a.oAUD_DATA, b.oAUD_DATA};
      if (dv == 6) begin
        rx_a = {rx_a[30:0], a.oAUD_DATA};
        rx_b = {rx_b[30:0], b.oAUD_DATA};
        if (slot == 16) begin
          if (sbq.size() == 0) chk("dac_sb_empty", 1, 0);
          else begin
            cur = sbq.pop_front();
            chk("left", {rx_a[15:0], rx_b[15:0]}, cur);
            have_left = 1'b1;
          end
        end
        if (slot == 0) begin
          if (have_left) chk("right", {rx_a[15:0], rx_b[15:0]}, cur);
          else chk("slot0_rst", {a.oAUD_DATA, b.oAUD_DATA}, 0);
        end
      end
`ifdef AUDIO_ADC_EN
      if (ph == 199) begin
        if (adcq.size() == 0) chk("adc_sb_empty", 1, 0);
        else tape_exp = adcq.pop_front();
      end
      chk("tapein", {a.tapein, b.tapein}, {2{tape_exp}});
`else
      chk("tapein_off", {a.tapein, b.tapein}, 0);
`endif
      if (ph == 0) begin
        f++;
        adc_w = adc_tab[f % 8];
        tm = $signed(adc_w) > 16'sh0200 ? 1'b1 : $signed(adc_w) < -16'sh0200 ? 1'b0 : tm;
        adcq.push_back(tm);
      end
      if (ph == 11) begin
        a.pcm = pcm_tab[f % 8];
        a.pulses = pul_tab[f % 8];
        sbq.push_back({mix_model(a.pcm, a.pulses, 2048), mix_model(a.pcm, a.pulses, 16384)});
      end else begin
        a.pcm = 8'($urandom);
        a.pulses = 4'($urandom);
      end
      a.iAUD_ADCDAT = (slot >= 1 && slot <= 16) ? adc_w[16 - slot] : 1'($urandom);
      t++;
      @(negedge clk18);
    end
  endtask
  initial begin
    a.pcm = 8'h80;
    a.pulses = 4'h0;
    a.iAUD_ADCDAT = 1'b0;
    adc_w = '0;
    cur = '0;
    f = -1;
    clear_model();
    repeat (3) @(posedge clk18);
    @(negedge clk18);
    chk_reset();
    reset_in = 1'b0;
    run(4 * 384 + 243);
    reset_in = 1'b1;
    repeat (3) begin
      @(negedge clk18);
      chk_reset();
    end
    reset_in = 1'b0;
    clear_model();
    run(5 * 384 + 20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/i2s_tape_audio.md
Name: i2s_tape_audio

Overview:
- Audio I2S master for the WM8731 codec on the DE1 board. Sits between the BK core's tape/sound outputs and the codec pins.
- Mixes the 8-bit PCM input and four 1-bit pulse sources (tape_out, beeper) into one 16-bit signed sample. Sends that sample to both DAC channels.
- Captures the left ADC channel and turns it into the digital tape_in signal for the core, using a hysteresis comparator.

Parameters:
- BCLK_DIV, 12: clk18 cycles per BCLK period. Must be even and >= 4. With 18.432 MHz, 12 gives 32 slots × 12 = 384 clk per frame, i.e. 48 kHz.
- PULSE_AMP, 16'h0800: signed contribution of each pulse bit (+ when high, − when low).
- HYST, 16'h0200: comparator threshold magnitude for tape_in.

Ports:
- clk18, input, 1: audio clock, 18.432 MHz.
- reset_in, input, 1: synchronous, active-high reset.
- pulses, input, 4: 1-bit sound sources.
- pcm, input, 8: unsigned PCM sample, midscale 8'h80.
- iAUD_ADCDAT, input, 1: codec ADC serial data.
- oAUD_BCK, output, 1: bit clock.
- oAUD_DACLRCK, output, 1: DAC frame clock. Low = left channel.
- oAUD_ADCLRCK, output, 1: ADC frame clock. Identical to oAUD_DACLRCK.
- oAUD_DATA, output, 1: DAC serial data.
- tapein, output, 1: digitized tape input.
- sample_strobe, output, 1: one-cycle pulse each time a new DAC sample is latched.

Behaviour:
- Reset:
  - All outputs are 0 on the clock after reset_in is sampled high. Counters and sample registers clear to 0.
  - Reset mid-frame aborts the frame. No partial-state carryover.
  - After release, the first frame starts at slot 0 with div_cnt = 0.
- Divider:
  - div_cnt counts 0..BCLK_DIV−1 and wraps.
  - oAUD_BCK is registered: 1 while div_cnt >= BCLK_DIV/2, else 0.
  - BCLK rises when div_cnt enters BCLK_DIV/2. It falls on wrap to 0.
- Slot counter:
  - bit_cnt (5 bits, 0..31) increments on each div_cnt wrap, i.e. each BCLK falling edge.
  - oAUD_DACLRCK = oAUD_ADCLRCK = bit_cnt[4], registered, so LRCK changes only on BCLK falling edges.
- Mixing (combinational, 18-bit signed):
  - pcm_s = sign-extended (pcm ^ 8'h80) << 7.
  - mix = pcm_s + Σ over i of (pulses[i] ? +PULSE_AMP : −PULSE_AMP).
  - Saturate mix to [−32768, 32767] to get sample16.
- DAC framing (I2S, one-bit delay, MSB first, 16-bit slots):
  - On the clock bit_cnt enters 1, latch frame_word = {sample16, sample16} and pulse sample_strobe for one clock.
  - oAUD_DATA changes only on BCLK falling edges. In slot n (1..31) it outputs frame_word[32−n].
  - In slot 0 it outputs frame_word[0] of the previous frame (the right LSB). After reset this is 0.
  - Inputs may change on any cycle. Only the value present at the latch clock is transmitted.
- ADC capture:
  - Sample iAUD_ADCDAT on BCLK rising edges in slots 1..16 into a 16-bit shift register, MSB first.
  - One clock after the rising edge of slot 16, compare the signed left sample:
    - greater than +HYST: tapein <= 1;
    - less than −HYST: tapein <= 0;
    - otherwise tapein holds.
  - tapein updates at most once per frame.
  - Right-channel ADC data is ignored.
- Simultaneous events: reset_in has priority over every update in the same cycle.

Optional Feature:
- AUDIO_ADC_EN defined: ADC shift register and hysteresis comparator are built as above.
- AUDIO_ADC_EN undefined:
  - No capture logic; iAUD_ADCDAT is unused.
  - tapein is constant 0.
  - oAUD_ADCLRCK is still driven identical to DACLRCK.

Test Plan:
- Free run after reset:
  - BCLK period is 12 clk with 6 high / 6 low.
  - LRCK toggles every 192 clk, only on BCLK falling edges.
  - First LRCK rise occurs 192 clk after reset release.
- pcm=8'hFF, pulses=4'h0, default PULSE_AMP:
  - sample = 16256−8192 = 16'h1F80.
  - Slots 1..16 and 17..31 + next slot 0 both carry 0001_1111_1000_0000.
  - sample_strobe pulses once per 384 clk.
- Saturation with PULSE_AMP=16'h4000, pcm=8'hFF, pulses=4'hF: serialized word is 16'h7FFF.
- Saturation with pcm=8'h00, pulses=4'h0: serialized word is 16'h8000.
- ADC (AUDIO_ADC_EN), left words driven in sequence:
  - 16'h0300 → tapein 1, one clock after the slot-16 rising edge.
  - Then 16'h0100 → tapein stays 1.
  - Then 16'hFD00 (−0x300) → tapein 0.
  - Then 16'hFF00 → tapein stays 0.
- Reset asserted in slot 20 for 3 clk:
  - All outputs are 0 on the next clock.
  - After release, timing restarts exactly as in the free-run scenario.
- Build without AUDIO_ADC_EN, iAUD_ADCDAT toggling randomly: tapein stays 0; DAC outputs are unchanged versus the enabled build.
